// File: rtl/instruction_loader_pkg.sv
// Shared constants and state encodings for the instruction loader.
package instruction_loader_pkg;

    localparam int BYTE_SIZE                  = 8;
    localparam int DEFAULT_WORD_SIZE_IN_BYTES = 4;
    localparam int DEFAULT_MEM_SIZE_IN_WORDS  = 64;

    localparam logic [31:0] INSTRUCTION_HALT = 32'hFC000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// MSB-first byte shift register with a byte index that wraps per word.
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
    localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE,
    localparam int IW  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_first,
    input  logic                 shift,
    input  logic [BYTE_SIZE-1:0] data,
    output logic [BUS-1:0]       word,
    output logic [IW-1:0]        index,
    output logic                 last
);

    assign last = (index == IW'(WORD_SIZE_IN_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word  <= '0;
            index <= '0;
        end else if (load_first) begin
            word  <= BUS'(data);
            index <= IW'(1);
        end else if (shift) begin
            word  <= BUS'({word, data});
            index <= last ? '0 : index + IW'(1);
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Packs UART bytes into instruction words and writes them to instruction memory.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
    parameter int MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS,
    parameter int TIMEOUT_CYCLES     = 100000,
    localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE,
    localparam int WCW = $clog2(MEM_SIZE_IN_WORDS) + 1,
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1,
    localparam int IW  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start_load,
    input  logic [BYTE_SIZE-1:0] i_rx_data,
    input  logic                 i_rx_valid,
    input  logic                 i_full_mem,
    output logic                 o_write_mem,
    output logic [BUS-1:0]       o_instruction,
    output logic [WCW-1:0]       o_word_count,
    output logic                 o_loading,
    output logic                 o_done,
    output logic                 o_error
);

    loader_state_t  state;
    loader_state_t  state_next;

    logic [BUS-1:0] word;
    logic [BUS-1:0] last_word;
    logic [IW-1:0]  index;
    logic           last;
    logic [TW-1:0]  to_cnt;
    logic [WCW-1:0] word_cnt;

    logic pk_clear;
    logic pk_load_first;
    logic pk_shift;
    logic to_clear;
    logic to_inc;
    logic wc_clear;
    logic wc_inc;
    logic write;

    instruction_loader_byte_packer #(
        .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
    ) u_packer (
        .clk       (i_clk),
        .reset     (i_reset),
        .clear     (pk_clear),
        .load_first(pk_load_first),
        .shift     (pk_shift),
        .data      (i_rx_data),
        .word      (word),
        .index     (index),
        .last      (last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            word_cnt  <= '0;
            last_word <= '0;
        end else begin
            state <= state_next;
            if (to_clear) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (wc_clear) begin
                word_cnt <= '0;
            end else if (wc_inc) begin
                word_cnt <= word_cnt + WCW'(1);
            end
            if (write) begin
                last_word <= word;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pk_clear      = 1'b0;
        pk_load_first = 1'b0;
        pk_shift      = 1'b0;
        to_clear      = 1'b0;
        to_inc        = 1'b0;
        wc_clear      = 1'b0;
        wc_inc        = 1'b0;
        write         = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start_load) begin
                    state_next = ST_RECEIVE;
                    pk_clear   = 1'b1;
                    to_clear   = 1'b1;
                    wc_clear   = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (i_rx_valid) begin
                    pk_shift = 1'b1;
                    to_clear = 1'b1;
                    if (last) begin
                        state_next = ST_WRITE;
                    end
                end else if (index != '0) begin
                    // Only a partially received word can time out.
                    if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_next = ST_ERROR;
                    end else begin
                        to_inc = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                to_clear = 1'b1;
                if (i_full_mem) begin
                    state_next = ST_ERROR;
                end else begin
                    write  = 1'b1;
                    wc_inc = (word_cnt != '1);
                    if (word == BUS'(INSTRUCTION_HALT)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_RECEIVE;
                        pk_load_first = i_rx_valid;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_write_mem   = write;
    assign o_instruction = (state == ST_WRITE) ? word : last_word;
    assign o_word_count  = word_cnt;
    assign o_loading     = (state == ST_RECEIVE) || (state == ST_WRITE);
    assign o_done        = (state == ST_DONE);
    assign o_error       = (state == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader with a word-level reference model.
module tb_instruction_loader;

    localparam int W    = 4;
    localparam int M    = 64;
    localparam int T    = 16;
    localparam int BUS  = 32;
    localparam int WCW  = 7;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic           full = 1'b0;
    logic           write_mem;
    logic [BUS-1:0] instruction;
    logic [WCW-1:0] word_count;
    logic           loading;
    logic           done;
    logic           error;

    always #5 clk = ~clk;

    instruction_loader #(
        .WORD_SIZE_IN_BYTES(W),
        .MEM_SIZE_IN_WORDS (M),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start_load (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_full_mem   (full),
        .o_write_mem  (write_mem),
        .o_instruction(instruction),
        .o_word_count (word_count),
        .o_loading    (loading),
        .o_done       (done),
        .o_error      (error)
    );

    typedef struct {
        logic [31:0] word;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic prev_wr = 1'b0;

    // Reference model: session flags plus the bytes of the word in progress.
    bit          m_active;
    bit          m_done;
    bit          m_err;
    int          m_count;
    int          m_idle;
    logic [31:0] m_last;
    logic [7:0]  m_buf[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_active = 0;
        m_done   = 0;
        m_err    = 0;
        m_count  = 0;
        m_idle   = 0;
        m_last   = '0;
        m_buf.delete();
    endfunction

    function automatic void model_step(bit s, bit v, logic [7:0] d);
        logic [31:0] w;
        if (s && !m_active) begin
            m_active = 1;
            m_done   = 0;
            m_err    = 0;
            m_count  = 0;
            m_idle   = 0;
            m_buf.delete();
        end else if (m_active && v) begin
            m_buf.push_back(d);
            m_idle = 0;
            if (m_buf.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) w = (w << 8) | 32'(m_buf[i]);
                m_buf.delete();
                if (full) begin
                    m_err    = 1;
                    m_active = 0;
                end else begin
                    sb.push_back('{w, cyc + 1});
                    m_last = w;
                    if (m_count < (1 << WCW) - 1) m_count++;
                    if (w == HALT) begin
                        m_done   = 1;
                        m_active = 0;
                    end
                end
            end
        end else if (m_active && m_buf.size() != 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_err    = 1;
                m_active = 0;
                m_buf.delete();
            end
        end
    endfunction

    task automatic cyc_in(bit s, bit v, logic [7:0] d);
        start    = s;
        rx_valid = v;
        rx_data  = d;
        model_step(s, v, d);
        @(posedge clk);
        #1;
        start    = 0;
        rx_valid = 0;
    endtask

    task automatic idle(int n);
        repeat (n) cyc_in(0, 0, 8'h00);
    endtask

    task automatic send_byte(logic [7:0] d, int gap);
        cyc_in(0, 1, d);
        idle(gap);
    endtask

    task automatic send_word(logic [31:0] w, int gap);
        for (int i = 0; i < W; i++) send_byte(w[31-8*i -: 8], gap);
    endtask

    task automatic do_reset(bit s, bit v);
        reset    = 1;
        start    = s;
        rx_valid = v;
        rx_data  = 8'h5A;
        model_reset();
        @(posedge clk);
        #1;
        reset    = 0;
        start    = 0;
        rx_valid = 0;
    endtask

    task automatic set_full(bit b);
        idle(2);
        full = b;
    endtask

    task automatic check_state(string tag);
        check({tag, ".write_mem"}, 64'(write_mem), 64'(0));
        check({tag, ".loading"}, 64'(loading), 64'(m_active));
        check({tag, ".done"}, 64'(done), 64'(m_done));
        check({tag, ".error"}, 64'(error), 64'(m_err));
        check({tag, ".word_count"}, 64'(word_count), 64'(m_count));
        check({tag, ".instruction"}, 64'(instruction), 64'(m_last));
    endtask

    always @(negedge clk) begin
        if (write_mem === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %0h want no write (cycle %0d)",
                         instruction, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("write_word", 64'(instruction), 64'(e.word));
                check("write_cycle", 64'(cyc), 64'(e.at));
                check("loading_in_write", 64'(loading), 64'(1));
            end
            if (prev_wr) begin
                vectors++;
                miscompares++;
                $display("FAIL write_width: got 2+ cycles want 1 (cycle %0d)", cyc);
            end
        end
        prev_wr <= (write_mem === 1'b1);
    end

    initial begin
        logic [31:0] w;
        int nwords;
        model_reset();
        do_reset(0, 0);
        check_state("reset");

        // Single word.
        cyc_in(1, 0, 8'h00);
        send_word(32'h20010005, 0);
        idle(2);
        check_state("one_word");

        // Two words then HALT; later bytes must not be written.
        do_reset(0, 0);
        cyc_in(1, 0, 8'h00);
        send_word(32'h11223344, 1);
        send_word(32'h55667788, 0);
        send_word(HALT, 0);
        idle(2);
        check_state("halt");
        send_word(32'hDEADBEEF, 0);
        idle(2);
        check_state("after_halt");

        // Memory full on the completing byte.
        cyc_in(1, 0, 8'h00);
        send_word(32'h0badf00d, 0);
        set_full(1);
        send_word(32'h12345678, 0);
        idle(2);
        check_state("full");
        set_full(0);

        // Inter-byte timeout, then recovery.
        cyc_in(1, 0, 8'h00);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        idle(T - 1);
        check_state("timeout_edge");
        idle(1);
        check_state("timeout");
        cyc_in(1, 0, 8'h00);
        send_word(32'hCAFE0001, 0);
        idle(2);
        check_state("after_timeout");

        // Byte arriving in the write cycle starts the next word.
        cyc_in(1, 0, 8'h00);
        send_word(32'h01020304, 0);
        send_word(32'hAABBCCDD, 0);
        idle(2);
        check_state("write_cycle_byte");

        // Reset mid-word wins over start and valid.
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        do_reset(1, 1);
        check_state("mid_reset");
        send_word(32'h99887766, 0);
        idle(2);
        check_state("ignored_after_reset");

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            cyc_in(1, 0, 8'h00);
            nwords = $urandom_range(1, 6);
            for (int n = 0; n < nwords && m_active; n++) begin
                w = $urandom;
                if (w == HALT) w = w ^ 32'h1;
                if ($urandom_range(0, 9) == 0) begin
                    send_byte(w[31:24], 0);
                    send_byte(w[23:16], 0);
                    idle(T);
                end else begin
                    if ($urandom_range(0, 9) == 0) set_full(1);
                    for (int i = 0; i < W; i++) begin
                        send_byte(w[31-8*i -: 8],
                                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, T - 3) : 0);
                    end
                    if (full) set_full(0);
                end
            end
            if (m_active) send_word(HALT, 0);
            idle(3);
            check_state("random");
        end

        idle(3);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
